// File: rtl/read_dma_arbiter.sv
// rtl/read_dma_arbiter.sv - round-robin arbiter sharing one AXI4 read DMA between requesters
module read_dma_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int ALIGN_BYTES     = 16,
  parameter int IDX_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]           req_len,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [NUM_REQ-1:0]              req_error,
  output logic [ADDR_WIDTH-1:0]           dma_start_addr,
  output logic [31:0]                     dma_transfer_length,
  output logic                            dma_start,
  input  logic                            dma_done,
  input  logic                            dma_error,
  input  logic [AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [NUM_REQ-1:0]              m_axis_tvalid,
  input  logic [NUM_REQ-1:0]              m_axis_tready,
  output logic                            busy,
  output logic [IDX_WIDTH-1:0]            grant_idx
);
  localparam int BEAT_BYTES = AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
  state_t state;

  logic [IDX_WIDTH-1:0]  ptr, winner, ptr_next;
  logic                  any_valid, len_ok, stream_on, beat_fire, last_expected;
  logic                  tlast_fault, fault_nxt, err;
  logic [31:0]           sel_len, beat_cnt, beat_cnt_nxt, exp_beats;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // Scan from ptr upward with wrap; iterating downward lets the closest valid slot win.
  always_comb begin
    logic [IDX_WIDTH:0] cand;
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_WIDTH+1)'(k);
      if (cand >= (IDX_WIDTH+1)'(NUM_REQ))
        cand = cand - (IDX_WIDTH+1)'(NUM_REQ);
      if (req_valid[cand[IDX_WIDTH-1:0]]) begin
        winner    = cand[IDX_WIDTH-1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign ptr_next = (winner == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign sel_len  = req_len[32*winner +: 32];
  assign sel_addr = req_addr[ADDR_WIDTH*winner +: ADDR_WIDTH];
  assign len_ok   = (sel_len != 32'd0) && ((sel_len % 32'(ALIGN_BYTES)) == 32'd0);

  assign stream_on     = (state != IDLE);
  assign busy          = stream_on;
  assign s_axis_tready = stream_on & m_axis_tready[grant_idx];
  assign m_axis_tvalid = (stream_on && s_axis_tvalid) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;

  // tlast must appear exactly on the final expected beat.
  assign beat_fire     = s_axis_tvalid & s_axis_tready;
  assign exp_beats     = dma_transfer_length / 32'(BEAT_BYTES);
  assign beat_cnt_nxt  = beat_cnt + {31'd0, beat_fire};
  assign last_expected = ((beat_cnt + 32'd1) == exp_beats);
  assign fault_nxt     = tlast_fault | (beat_fire & (s_axis_tlast != last_expected));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state               <= IDLE;
      ptr                 <= '0;
      grant_idx           <= '0;
      dma_start_addr      <= '0;
      dma_transfer_length <= '0;
      dma_start           <= 1'b0;
      req_ready           <= '0;
      req_done            <= '0;
      req_error           <= '0;
      beat_cnt            <= '0;
      tlast_fault         <= 1'b0;
      err                 <= 1'b0;
    end else begin
      req_ready <= '0;
      req_done  <= '0;
      req_error <= '0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_idx         <= winner;
            ptr               <= ptr_next;
            req_ready[winner] <= 1'b1;
            if (len_ok) begin
              dma_start_addr      <= sel_addr;
              dma_transfer_length <= sel_len;
              dma_start           <= 1'b1;
              beat_cnt            <= '0;
              tlast_fault         <= 1'b0;
              state               <= RUN;
            end else begin
              req_error[winner] <= 1'b1;
            end
          end
        end
        RUN: begin
          beat_cnt    <= beat_cnt_nxt;
          tlast_fault <= fault_nxt;
          if (dma_done) begin
            dma_start <= 1'b0;
            err       <= dma_error | (beat_cnt_nxt != exp_beats) | fault_nxt;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          beat_cnt    <= beat_cnt_nxt;
          tlast_fault <= fault_nxt;
          if (!dma_done) begin
            req_done[grant_idx]  <= 1'b1;
            req_error[grant_idx] <= err;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_read_dma_arbiter.sv
// tb/tb_read_dma_arbiter.sv - self-checking bench for read_dma_arbiter
module tb_read_dma_arbiter;
  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   req_valid;
  logic [255:0] req_addr;
  logic [127:0] req_len;
  logic [3:0]   req_ready, req_done, req_error;
  logic [63:0]  dma_start_addr;
  logic [31:0]  dma_transfer_length;
  logic         dma_start, dma_done, dma_error;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tlast;
  logic [3:0]   m_axis_tvalid, m_axis_tready;
  logic         busy;
  logic [1:0]   grant_idx;

  read_dma_arbiter dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .req_done(req_done), .req_error(req_error),
    .dma_start_addr(dma_start_addr), .dma_transfer_length(dma_transfer_length),
    .dma_start(dma_start), .dma_done(dma_done), .dma_error(dma_error),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .grant_idx(grant_idx)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          idx;
    logic [63:0] addr;
    logic [31:0] len;
    bit          dma_err;
    bit          bad_tlast;
    bit          stall;
    bit          exp_reject;
    bit          exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_owner = 0;
  int          m_fire_cnt = 0;
  int          fire_base = 0;
  int          stall_tag = -1;
  bit          stall_cfg = 0;
  bit          dma_err_cfg = 0;
  bit          drop_tlast = 0;
  bit          idle_done = 0;
  logic [32:0] sb_q[$];
  int          exp_grant_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input logic [63:0] addr, input logic [31:0] len);
    req_addr[idx*64 +: 64] = addr;
    req_len[idx*32 +: 32]  = len;
    req_valid[idx]         = 1'b1;
  endtask

  // DMA model: streams len/4 beats once dma_start is seen, then runs the done/error handshake.
  initial begin : dma_model
    int nb, b, guard;
    bit fired, abort;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    dma_done = 1'b0; dma_error = 1'b0;
    forever begin
      @(negedge aclk);
      if (dma_start && !areset) begin
        nb = int'(dma_transfer_length / 4);
        b = 0; guard = 0; abort = 0;
        while (b < nb && !abort) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = $urandom;
          s_axis_tlast  = (b == nb - 1) && !drop_tlast;
          sb_q.push_back({s_axis_tlast, s_axis_tdata});
          fired = 0;
          while (!fired && !abort) begin
            #4;
            fired = s_axis_tready;
            @(negedge aclk);
            guard++;
            if (areset || guard > 400) abort = 1;
          end
          b++;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        if (!abort) begin
          dma_done = 1'b1; dma_error = dma_err_cfg;
          while (dma_start && !areset && guard < 400) begin @(negedge aclk); guard++; end
          @(negedge aclk);
          dma_done = 1'b0; dma_error = 1'b0;
        end else begin
          sb_q.delete();
        end
      end else begin
        dma_done = idle_done; dma_error = idle_done;
      end
    end
  end

  // Sink: drives per-requester ready (with an optional stall) and checks routed beats against the scoreboard.
  initial begin : sink
    int stall_left, stalled_for;
    logic [32:0] exp_beat;
    stall_left = 0; stalled_for = -1; m_axis_tready = 4'hF;
    forever begin
      @(negedge aclk);
      if (stall_left > 0) begin
        m_axis_tready = 4'b0111;
        stall_left--;
      end else begin
        m_axis_tready = 4'b1111;
      end
      #2;
      if (m_axis_tready[3] == 1'b0) check("stall_s_tready", s_axis_tready, 0);
      #2;
      if (m_axis_tvalid != 4'b0) begin
        check("tvalid_route", m_axis_tvalid, 64'(1) << exp_owner);
        if ((m_axis_tvalid & m_axis_tready) != 4'b0) begin
          m_fire_cnt++;
          check("sb_has_beat", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            exp_beat = sb_q.pop_front();
            check("m_tdata", m_axis_tdata, exp_beat[31:0]);
            check("m_tlast", m_axis_tlast, exp_beat[32]);
          end
          if (stall_cfg && stalled_for != stall_tag && (m_fire_cnt - fire_base) == 3) begin
            stalled_for = stall_tag;
            stall_left  = 10;
          end
        end
      end
    end
  end

  task automatic serve(input int exp_idx, input logic [63:0] exp_addr, input logic [31:0] exp_len,
                       input bit exp_reject, input bit exp_err);
    int cyc, got;
    exp_owner = exp_idx;
    cyc = 0;
    while (req_ready == 4'b0 && cyc < 50) begin @(negedge aclk); cyc++; end
    check("req_ready_seen", req_ready != 4'b0, 1);
    if (req_ready == 4'b0) return;
    got = 0;
    for (int i = 0; i < 4; i++) if (req_ready[i]) got = i;
    check("req_ready", req_ready, 64'(1) << exp_idx);
    check("grant_idx", grant_idx, exp_idx);
    check("accept_error", req_error, exp_reject ? (64'(1) << exp_idx) : 64'(0));
    check("busy_accept", busy, !exp_reject);
    check("dma_start_accept", dma_start, !exp_reject);
    req_valid[got] = 1'b0;
    if (exp_reject) begin
      @(negedge aclk);
      check("reject_busy", busy, 0);
      check("reject_dma_start", dma_start, 0);
      check("reject_ready_pulse", req_ready, 0);
      return;
    end
    check("dma_addr", dma_start_addr, exp_addr);
    check("dma_len", dma_transfer_length, exp_len);
    fire_base = m_fire_cnt;
    cyc = 0;
    while (req_done == 4'b0 && cyc < 500) begin @(negedge aclk); cyc++; end
    check("req_done_seen", req_done != 4'b0, 1);
    if (req_done == 4'b0) return;
    check("req_done", req_done, 64'(1) << exp_idx);
    check("done_error", req_error, exp_err ? (64'(1) << exp_idx) : 64'(0));
    check("beat_count", m_fire_cnt - fire_base, exp_len / 4);
    check("sb_drained", sb_q.size(), 0);
    check("busy_done", busy, 0);
  endtask

  initial begin : main
    vec_t vecs[6];
    int   cyc;
    vecs[0] = '{0, 64'h1000, 32'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 64'h2000, 32'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2, 64'h3000, 32'd48, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 64'h4000, 32'd16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1, 64'h5000, 32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3, 64'h6000, 32'd32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    areset = 1'b1; req_valid = '0; req_addr = '0; req_len = '0;
    repeat (2) @(negedge aclk);
    check("rst_busy", busy, 0);
    check("rst_dma_start", dma_start, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_req_done", req_done, 0);
    check("rst_req_error", req_error, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_dma_addr", dma_start_addr, 0);
    areset = 1'b0;
    @(negedge aclk);

    for (int r = 0; r < 6; r++) begin
      dma_err_cfg = vecs[r].dma_err;
      drop_tlast  = vecs[r].bad_tlast;
      stall_cfg   = vecs[r].stall;
      stall_tag   = r;
      set_req(vecs[r].idx, vecs[r].addr, vecs[r].len);
      serve(vecs[r].idx, vecs[r].addr, vecs[r].len, vecs[r].exp_reject, vecs[r].exp_err);
      @(negedge aclk);
    end
    dma_err_cfg = 0; drop_tlast = 0; stall_cfg = 0;

    // All four requesters at once with the pointer back at 0.
    for (int i = 0; i < 4; i++) begin
      set_req(i, 64'h8000 + 64'(i) * 64'h100, 32'd32);
      exp_grant_q.push_back(i);
    end
    while (exp_grant_q.size() != 0) begin
      cyc = exp_grant_q.pop_front();
      serve(cyc, 64'h8000 + 64'(cyc) * 64'h100, 32'd32, 1'b0, 1'b0);
    end
    set_req(0, 64'h9000, 32'd32);
    set_req(2, 64'h9200, 32'd32);
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(2);
    while (exp_grant_q.size() != 0) begin
      cyc = exp_grant_q.pop_front();
      serve(cyc, 64'h9000 + 64'(cyc) * 64'h100, 32'd32, 1'b0, 1'b0);
    end

    // A done level while idle must not start or complete anything.
    @(negedge aclk);
    idle_done = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      check("idle_done_busy", busy, 0);
      check("idle_done_req_done", req_done, 0);
    end
    idle_done = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset on beat 5 of a 16-beat transfer from requester 2 (pointer then sits at 3).
    exp_owner = 2;
    set_req(2, 64'hA000, 32'd64);
    cyc = 0;
    while (req_ready == 4'b0 && cyc < 50) begin @(negedge aclk); cyc++; end
    check("rst_run_ready", req_ready, 4'b0100);
    req_valid[2] = 1'b0;
    fire_base = m_fire_cnt;
    cyc = 0;
    while ((m_fire_cnt - fire_base) < 5 && cyc < 100) begin @(negedge aclk); cyc++; end
    check("rst_run_beats", m_fire_cnt - fire_base, 5);
    areset = 1'b1;
    #1;
    check("rst_run_dma_start", dma_start, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_tvalid", m_axis_tvalid, 0);
    check("rst_run_s_tready", s_axis_tready, 0);
    check("rst_run_grant", grant_idx, 0);
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    set_req(1, 64'hB100, 32'd32);
    set_req(3, 64'hB300, 32'd32);
    serve(1, 64'hB100, 32'd32, 1'b0, 1'b0);
    serve(3, 64'hB300, 32'd32, 1'b0, 1'b0);

    repeat (5) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
